// File: rtl/fighter_pkg.sv
// Shared state encoding and default parameters for the fighter controller.
package fighter_pkg;

    localparam int DEF_HEALTH_W        = 4;
    localparam int DEF_MAX_HEALTH      = 15;
    localparam int DEF_PUNCH_CYCLES    = 8;
    localparam int DEF_COOLDOWN_CYCLES = 16;
    localparam int DEF_STAMINA_MAX     = 63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RPUNCH,
        ST_LPUNCH,
        ST_COOLDOWN,
        ST_BLOCK,
        ST_DEAD
    } fighter_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fighter_control_if.sv
// Player controls, incoming hits and fighter status grouped as one bus.
interface fighter_control_if
    import fighter_pkg::*;
#(
    parameter int HEALTH_W = DEF_HEALTH_W
);
    logic                rgo;
    logic                lgo;
    logic                block;
    logic                hit_valid;
    logic [HEALTH_W-1:0] hit_dmg;
    logic [HEALTH_W-1:0] health;
    logic                rpunch;
    logic                lpunch;
    logic                can_be_hit;
    logic                blocking;
    logic                dead;
    logic                punch_done;

    modport master (
        output rgo, lgo, block, hit_valid, hit_dmg,
        input  health, rpunch, lpunch, can_be_hit, blocking, dead, punch_done
    );

    modport slave (
        input  rgo, lgo, block, hit_valid, hit_dmg,
        output health, rpunch, lpunch, can_be_hit, blocking, dead, punch_done
    );
endinterface

// File: rtl/fighter_timer.sv
// Loadable down-counter shared by punch and cooldown phases; done while it sits at zero.
module fighter_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);
endmodule

// File: rtl/fighter_control.sv
// Fighter state machine: punches with cooldown, stamina-limited blocking, health and death.
module fighter_control
    import fighter_pkg::*;
#(
    parameter int HEALTH_W        = DEF_HEALTH_W,
    parameter int MAX_HEALTH      = DEF_MAX_HEALTH,
    parameter int PUNCH_CYCLES    = DEF_PUNCH_CYCLES,
    parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
    parameter int STAMINA_MAX     = DEF_STAMINA_MAX
) (
    input logic              clock,
    input logic              reset_n,
    fighter_control_if.slave bus
);
    localparam int TIMER_W = $clog2(max_int(PUNCH_CYCLES, COOLDOWN_CYCLES) + 1);
    localparam int STAM_W  = $clog2(STAMINA_MAX + 1);

    // The timer is loaded with N-1 so that done marks the Nth (last) cycle of a phase.
    localparam logic [TIMER_W-1:0]  PUNCH_LOAD  = TIMER_W'(PUNCH_CYCLES - 1);
    localparam logic [TIMER_W-1:0]  COOL_LOAD   = TIMER_W'(COOLDOWN_CYCLES - 1);
    localparam logic [STAM_W-1:0]   STAM_FULL   = STAM_W'(STAMINA_MAX);
    localparam logic [HEALTH_W-1:0] HEALTH_FULL = HEALTH_W'(MAX_HEALTH);

    fighter_state_t      state;
    fighter_state_t      next_state;
    logic [HEALTH_W-1:0] health;
    logic [STAM_W-1:0]   stamina;
    logic                timer_load;
    logic [TIMER_W-1:0]  timer_value;
    logic                timer_done;
    logic                can_be_hit;

    fighter_timer #(.WIDTH(TIMER_W)) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_IDLE: begin
                if (bus.rgo) begin
                    next_state  = ST_RPUNCH;
                    timer_load  = 1'b1;
                    timer_value = PUNCH_LOAD;
                end else if (bus.lgo) begin
                    next_state  = ST_LPUNCH;
                    timer_load  = 1'b1;
                    timer_value = PUNCH_LOAD;
                end else if (bus.block && stamina != '0) begin
                    next_state = ST_BLOCK;
                end
            end
            ST_RPUNCH, ST_LPUNCH: begin
                if (timer_done) begin
                    next_state  = ST_COOLDOWN;
                    timer_load  = 1'b1;
                    timer_value = COOL_LOAD;
                end
            end
            ST_COOLDOWN: begin
                if (timer_done) begin
                    next_state = ST_IDLE;
                end
            end
            ST_BLOCK: begin
                // Leave on the edge where stamina drains from 1 to 0.
                if (!(bus.block && stamina > STAM_W'(1))) begin
                    next_state = ST_IDLE;
                end
            end
            ST_DEAD: begin
                next_state = ST_DEAD;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if (health == '0) begin
            next_state = ST_DEAD;
            timer_load = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            health <= HEALTH_FULL;
        end else if (bus.hit_valid && can_be_hit) begin
            health <= (bus.hit_dmg >= health) ? '0 : health - bus.hit_dmg;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stamina <= STAM_FULL;
        end else if (state == ST_BLOCK) begin
            if (stamina != '0) begin
                stamina <= stamina - STAM_W'(1);
            end
        end else if (state != ST_DEAD && stamina != STAM_FULL) begin
            stamina <= stamina + STAM_W'(1);
        end
    end

    assign can_be_hit     = (state == ST_IDLE) || (state == ST_RPUNCH) ||
                            (state == ST_LPUNCH) || (state == ST_COOLDOWN);
    assign bus.can_be_hit = can_be_hit;
    assign bus.rpunch     = (state == ST_RPUNCH);
    assign bus.lpunch     = (state == ST_LPUNCH);
    assign bus.blocking   = (state == ST_BLOCK);
    assign bus.dead       = (state == ST_DEAD);
    assign bus.punch_done = ((state == ST_RPUNCH) || (state == ST_LPUNCH)) && timer_done;
    assign bus.health     = health;
endmodule

// File: tb/tb_fighter_control.sv
// Directed bench for fighter_control: a vector table plus hand-timed multi-cycle sequences.
module tb_fighter_control;
    import fighter_pkg::*;

    // Flag order: {rpunch, lpunch, can_be_hit, blocking, dead, punch_done}
    typedef struct packed {
        logic [3:0] health;
        logic [5:0] flags;
    } out_t;

    typedef struct {
        logic       rgo;
        logic       lgo;
        logic       block;
        logic       hit_valid;
        logic [3:0] hit_dmg;
        out_t       exp;
    } vec_t;

    localparam logic [5:0] F_IDLE = 6'b001000;
    localparam logic [5:0] F_RP   = 6'b101000;
    localparam logic [5:0] F_RPD  = 6'b101001;
    localparam logic [5:0] F_LP   = 6'b011000;
    localparam logic [5:0] F_BLK  = 6'b000100;
    localparam logic [5:0] F_DEAD = 6'b000010;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    vec_t table_v[10];

    fighter_control_if #(.HEALTH_W(4)) bus();

    fighter_control #(
        .HEALTH_W        (4),
        .MAX_HEALTH      (15),
        .PUNCH_CYCLES    (8),
        .COOLDOWN_CYCLES (16),
        .STAMINA_MAX     (63)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    function automatic out_t mk(input logic [3:0] h, input logic [5:0] f);
        out_t o;
        o.health = h;
        o.flags  = f;
        return o;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic b,
                                 input logic hv, input logic [3:0] dmg);
        bus.rgo       = r;
        bus.lgo       = l;
        bus.block     = b;
        bus.hit_valid = hv;
        bus.hit_dmg   = dmg;
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        act.health = bus.health;
        act.flags  = {bus.rpunch, bus.lpunch, bus.can_be_hit, bus.blocking, bus.dead, bus.punch_done};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got health=%0d flags=%b, expected health=%0d flags=%b",
                     name, act.health, act.flags, exp.health, exp.flags);
        end
    endtask

    task automatic checkStamina(input string name, input int exp);
        checks++;
        if (int'(dut.stamina) != exp) begin
            errors++;
            $display("[TB] FAIL %s: got stamina=%0d, expected stamina=%0d", name, dut.stamina, exp);
        end
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_outputs", mk(4'd15, F_IDLE));
        checkStamina("reset_stamina", 63);
        reset_n = 1'b1;
    endtask

    initial begin
        table_v[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, mk(4'd15, F_IDLE)};
        table_v[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, mk(4'd12, F_IDLE)};
        table_v[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, mk(4'd12, F_IDLE)};
        table_v[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd5, mk(4'd12, F_IDLE)};
        table_v[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, mk(4'd12, F_BLK)};
        table_v[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd3, mk(4'd12, F_BLK)};
        table_v[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, mk(4'd12, F_BLK)};
        table_v[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, mk(4'd12, F_IDLE)};
        table_v[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd2, mk(4'd10, F_LP)};
        table_v[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1, mk(4'd9, F_LP)};

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        doReset();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(table_v[i].rgo, table_v[i].lgo, table_v[i].block,
                          table_v[i].hit_valid, table_v[i].hit_dmg);
            tick();
            checkOutput($sformatf("vec%0d", i), table_v[i].exp);
        end

        // Full punch/cooldown timeline with both-buttons priority, ignored controls and auto-repeat.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        for (int c = 1; c <= 26; c++) begin
            logic [3:0] h;
            h = (c >= 13) ? 4'd12 : 4'd15;
            if (c <= 8) begin
                checkOutput($sformatf("punch_c%0d", c), mk(h, (c == 8) ? F_RPD : F_RP));
                applyStimulus(1'b0, 1'(c % 2), 1'((c / 2) % 2), 1'b0, 4'd0);
            end else if (c <= 25) begin
                checkOutput($sformatf("cool_c%0d", c), mk(h, F_IDLE));
                if (c <= 24) begin
                    applyStimulus(1'b1, 1'(c % 2), 1'((c / 2) % 2), c == 12, (c == 12) ? 4'd3 : 4'd0);
                end else begin
                    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
                end
            end else begin
                checkOutput($sformatf("repeat_c%0d", c), mk(h, F_RP));
            end
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Block held from full stamina, then a re-press with empty stamina.
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        for (int c = 1; c <= 63; c++) begin
            checkOutput($sformatf("block_c%0d", c), mk(4'd15, F_BLK));
            tick();
        end
        checkOutput("block_exhausted", mk(4'd15, F_IDLE));
        checkStamina("stamina_empty", 0);
        tick();
        checkOutput("block_repress_ignored", mk(4'd15, F_IDLE));
        checkStamina("stamina_recharge", 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Overkill hit, death on the following edge, then sticky DEAD.
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd10);
        tick();
        checkOutput("hit_to_5", mk(4'd5, F_IDLE));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        tick();
        checkOutput("health_zero", mk(4'd0, F_IDLE));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        checkOutput("dead_entered", mk(4'd0, F_DEAD));
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'(i % 2), 1'((i / 2) % 2), 1'((i + 1) % 2), 1'b1, 4'd1);
            tick();
            checkOutput($sformatf("dead_sticky%0d", i), mk(4'd0, F_DEAD));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Asynchronous reset in the middle of a punch after stamina and health were spent.
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        repeat (20) tick();
        checkStamina("stamina_drained", 44);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        checkOutput("midrst_c1", mk(4'd15, F_RP));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd4);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        checkOutput("midrst_c2", mk(4'd11, F_RP));
        tick();
        checkOutput("midrst_c3", mk(4'd11, F_RP));
        tick();
        checkOutput("midrst_c4", mk(4'd11, F_RP));
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_async", mk(4'd15, F_IDLE));
        checkStamina("midrst_stamina", 63);
        tick();
        checkOutput("midrst_held", mk(4'd15, F_IDLE));
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("post_rst%0d", i), mk(4'd15, F_IDLE));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
